led_string_serializer: RTL and testbench
========================================

# led_string_serializer

Serializer for one WS2812-style LED string, on the 20 MHz pixel clock downstream of the parallel string driver. Takes one GRB pixel word at a time over a valid/ready handshake, emits the single-wire pulse-width-coded waveform on `sdi`, and inserts the latch (reset-low) period after each frame of `N_LEDS` pixels. Starvation mid-frame is reported as an underrun and the frame is terminated with a latch.

## Interface

Parameters:
- `N_LEDS`, 128, pixels per frame; frame ends after this many pixels.
- `BIT_CYCLES`, 25, clocks per data bit (1.25 us at 20 MHz).
- `T0H_CYCLES`, 8, high clocks for a `0` bit (0.40 us).
- `T1H_CYCLES`, 16, high clocks for a `1` bit (0.80 us).
- `LATCH_CYCLES`, 1200, low clocks after a frame or underrun (60 us).

Ports (clock is `clk`, reset is `reset`; one clock; reset is synchronous and active-high):
- `clk`  input  1  20 MHz pixel clock.
- `reset`  input  1  synchronous, active-high reset.
- `pixel_data`  input  PIXEL_BITS  pixel word, MSB sent first; PIXEL_BITS = 24, or 32 with RGBW (see Configuration).
- `pixel_valid`  input  1  `pixel_data` valid.
- `pixel_ready`  output  1  holding register empty; transfer on `pixel_valid && pixel_ready`.
- `sdi`  output  1  registered serial line to the string.
- `busy`  output  1  state is not IDLE.
- `underrun`  output  1  one-cycle pulse: pixel needed mid-frame, none held.
- `pixel_index`  output  $clog2(N_LEDS+1)  pixels completed in current frame.

## Operation

- One-entry holding register (`hold`, `hold_full`) plus PIXEL_BITS shift register; `pixel_ready = !hold_full` in every state.
- Handshake sets `hold_full` next cycle; a load into the shift register clears it in the same cycle a new handshake may set it (set wins).
- States: IDLE, SEND, LATCH.
- IDLE: `sdi`=0. If `hold_full`: load shift register, bit counter = 0, cycle counter = 0, `pixel_index` = 0, go SEND.
- SEND: `sdi` = (cycle counter < (current bit ? T1H_CYCLES : T0H_CYCLES)). Cycle counter 0..BIT_CYCLES-1 then wraps; on wrap, shift left and bit counter increments.
- End of pixel (last cycle of last bit): `pixel_index` increments. If new index == N_LEDS: go LATCH. Else if `hold_full`: load, continue SEND with no gap. Else: pulse `underrun`, go LATCH.
- LATCH: `sdi`=0 for LATCH_CYCLES clocks. Then if `hold_full` load and go SEND (new frame, `pixel_index`=0), else IDLE.
- Pixels may be accepted during LATCH and IDLE; only one is held.
- Underrun does not discard later data: the next pixel starts a new frame at index 0.

## Timing

- Reset values: `sdi`=0, `busy`=0, `underrun`=0, `pixel_ready`=1, `pixel_index`=0, state IDLE, hold empty.
- Reset mid-frame: `sdi` low on the next cycle, held pixel dropped, no `underrun` pulse.
- Handshake at cycle t from IDLE: `hold_full` at t+1, load and SEND at t+1, first `sdi` high at t+2.
- Back-to-back pixels: bit periods exactly BIT_CYCLES apart across pixel boundaries; frame of N_LEDS pixels is exactly N_LEDS×PIXEL_BITS×BIT_CYCLES clocks of SEND.
- `underrun` asserts in the cycle SEND→LATCH occurs; `sdi` is already low there (T1H_CYCLES < BIT_CYCLES required).
- Counters sized for BIT_CYCLES and LATCH_CYCLES; no wrap besides the defined ones.

## Configuration

- `LED_SERIALIZER_RGBW_EN` defined: PIXEL_BITS = 32 (GRBW), 32 bits per pixel.
- Not defined: PIXEL_BITS = 24 (GRB), 24 bits per pixel. No other behaviour differs.

## Test plan

- Reset, idle 50 clocks -> `sdi`=0, `busy`=0, `pixel_ready`=1, no `underrun`.
- N_LEDS=1, one pixel 0xFF0000 -> 8 bits of 16 high/9 low, then 16 bits of 8 high/17 low, then 1200 low clocks, then `busy`=0.
- N_LEDS=2, pixels 0x000001 and 0x800000 back-to-back -> continuous 48-bit train, bit 24 (LSB of first) and bit 25 (MSB of second) both 16-high, no gap, `pixel_index` 0→1→2.
- N_LEDS=4, supply 2 pixels then stop -> `underrun` one-cycle pulse at end of pixel 2, LATCH of 1200 clocks; next pixel starts frame with `pixel_index`=0.
- `reset` asserted mid-bit during a high phase -> `sdi` 0 next cycle, `busy`=0, held pixel discarded.
- With `LED_SERIALIZER_RGBW_EN`, N_LEDS=1, pixel 0x00000001 -> 31 zero bits then one `1` bit (800 clocks SEND).

Source files
------------

// File: rtl/led_string_serializer.sv
// WS2812-style single-wire serializer: one-pixel holding register, pulse-width bit coding,
// frame latch and underrun detection. Define LED_SERIALIZER_RGBW_EN for 32-bit GRBW pixels.
module led_string_serializer #(
    parameter int N_LEDS       = 128,
    parameter int BIT_CYCLES   = 25,
    parameter int T0H_CYCLES   = 8,
    parameter int T1H_CYCLES   = 16,
    parameter int LATCH_CYCLES = 1200,
`ifdef LED_SERIALIZER_RGBW_EN
    localparam int PIXEL_BITS  = 32,
`else
    localparam int PIXEL_BITS  = 24,
`endif
    localparam int IDX_W       = $clog2(N_LEDS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PIXEL_BITS-1:0] pixel_data,
    input  logic                  pixel_valid,
    output logic                  pixel_ready,
    output logic                  sdi,
    output logic                  busy,
    output logic                  underrun,
    output logic [IDX_W-1:0]      pixel_index
);

    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = $clog2(PIXEL_BITS);
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
    localparam logic [CYC_W-1:0] T0H      = CYC_W'(T0H_CYCLES);
    localparam logic [CYC_W-1:0] T1H      = CYC_W'(T1H_CYCLES);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PIXEL_BITS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(N_LEDS);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_LATCH} state_t;

    state_t                state_q, state_d;
    logic [PIXEL_BITS-1:0] hold_q, hold_d;
    logic [PIXEL_BITS-1:0] shift_q, shift_d;
    logic                  hold_full_q, hold_full_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  sdi_q, sdi_d;

    logic                  handshake;
    logic                  load;
    logic                  pixel_end;
    logic [IDX_W-1:0]      idx_inc;

    assign handshake = pixel_valid && !hold_full_q;
    assign pixel_end = (state_q == ST_SEND) && (cyc_q == CYC_LAST) && (bit_q == BIT_LAST);
    assign idx_inc   = idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            shift_q     <= '0;
            hold_full_q <= 1'b0;
            cyc_q       <= '0;
            bit_q       <= '0;
            lat_q       <= '0;
            idx_q       <= '0;
            sdi_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            shift_q     <= shift_d;
            hold_full_q <= hold_full_d;
            cyc_q       <= cyc_d;
            bit_q       <= bit_d;
            lat_q       <= lat_d;
            idx_q       <= idx_d;
            sdi_q       <= sdi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        lat_d   = lat_q;
        idx_d   = idx_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cyc_q != CYC_LAST) begin
                    cyc_d = cyc_q + CYC_W'(1);
                end else begin
                    cyc_d = '0;
                    if (bit_q != BIT_LAST) begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = {shift_q[PIXEL_BITS-2:0], 1'b0};
                    end else begin
                        idx_d = idx_inc;
                        if (idx_inc != IDX_FULL && hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_LATCH;
                            lat_d   = '0;
                        end
                    end
                end
            end
            ST_LATCH: begin
                if (lat_q != LAT_LAST) begin
                    lat_d = lat_q + LAT_W'(1);
                end else if (hold_full_q) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            shift_d = hold_q;
            cyc_d   = '0;
            bit_d   = '0;
        end

        // A fresh handshake wins over the clear caused by a load in the same cycle.
        hold_full_d = handshake ? 1'b1 : (load ? 1'b0 : hold_full_q);
        hold_d      = handshake ? pixel_data : hold_q;

        // sdi is registered, so it is computed from the values the counters take next.
        sdi_d = (state_d == ST_SEND) && (cyc_d < (shift_d[PIXEL_BITS-1] ? T1H : T0H));
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        pixel_ready = !hold_full_q;
        underrun    = pixel_end && (idx_inc != IDX_FULL) && !hold_full_q;
        sdi         = sdi_q;
        pixel_index = idx_q;
    end

endmodule

// File: tb/tb_led_string_serializer.sv
// Bench for led_string_serializer: three instances (N_LEDS = 1, 2, 4) checked every cycle
// against a pixel-time model, plus directed literal checks for each scenario.
module tb_led_string_serializer;

`ifdef LED_SERIALIZER_RGBW_EN
    localparam int PB = 32;
`else
    localparam int PB = 24;
`endif
    localparam int BC  = 25;
    localparam int T0H = 8;
    localparam int T1H = 16;
    localparam int LAT = 1200;
    localparam int FR  = PB * BC;

    logic          clk = 1'b0;
    logic          reset;
    logic [PB-1:0] pdata  [3];
    logic          pvalid [3];
    logic          prdy   [3];
    logic          sdi_w  [3];
    logic          busy_w [3];
    logic          und_w  [3];
    logic [7:0]    idx_w  [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int NLV = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
        logic [$clog2(NLV+1)-1:0] pidx;
        led_string_serializer #(
            .N_LEDS(NLV), .BIT_CYCLES(BC), .T0H_CYCLES(T0H),
            .T1H_CYCLES(T1H), .LATCH_CYCLES(LAT)
        ) u_dut (
            .clk(clk), .reset(reset), .pixel_data(pdata[gi]), .pixel_valid(pvalid[gi]),
            .pixel_ready(prdy[gi]), .sdi(sdi_w[gi]), .busy(busy_w[gi]),
            .underrun(und_w[gi]), .pixel_index(pidx)
        );
        assign idx_w[gi] = 8'(pidx);
    end

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input int u, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0d, expected %0d at %0t", name, u, act, exp, $time);
    endfunction

    function automatic int nl(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 2 : 4);
    endfunction

    // Model: phase 0 idle / 1 sending / 2 latch; m_t is the clock offset inside the current pixel.
    int            m_phase [3];
    int            m_t     [3];
    int            m_idx   [3];
    int            m_lat   [3];
    logic          m_hf    [3];
    logic [PB-1:0] m_hold  [3];
    logic [PB-1:0] m_pix   [3];
    bit            started = 1'b0;

    initial begin : model
        bit hs, ld;
        forever begin
            @(posedge clk);
            for (int u = 0; u < 3; u++) begin
                if (reset) begin
                    m_phase[u] = 0; m_t[u] = 0; m_idx[u] = 0; m_lat[u] = 0;
                    m_hf[u] = 1'b0; m_hold[u] = '0; m_pix[u] = '0;
                end else begin
                    hs = pvalid[u] && !m_hf[u];
                    ld = 1'b0;
                    case (m_phase[u])
                        0: if (m_hf[u]) begin ld = 1'b1; m_idx[u] = 0; end
                        1: begin
                            if (m_t[u] == FR - 1) begin
                                m_idx[u]++;
                                if (m_idx[u] != nl(u) && m_hf[u]) ld = 1'b1;
                                else begin m_phase[u] = 2; m_lat[u] = 0; end
                            end else m_t[u]++;
                        end
                        default: begin
                            if (m_lat[u] == LAT - 1) begin
                                if (m_hf[u]) begin ld = 1'b1; m_idx[u] = 0; end
                                else m_phase[u] = 0;
                            end else m_lat[u]++;
                        end
                    endcase
                    if (ld) begin m_phase[u] = 1; m_t[u] = 0; m_pix[u] = m_hold[u]; end
                    if (hs) begin m_hf[u] = 1'b1; m_hold[u] = pdata[u]; end
                    else if (ld) m_hf[u] = 1'b0;
                end
            end
            started = 1'b1;
        end
    end

    initial begin : compare
        int e_sdi, e_und, bitv;
        forever begin
            @(negedge clk);
            if (started) begin
                for (int u = 0; u < 3; u++) begin
                    e_sdi = 0;
                    e_und = 0;
                    if (m_phase[u] == 1) begin
                        bitv  = m_pix[u][PB - 1 - m_t[u] / BC] ? T1H : T0H;
                        e_sdi = ((m_t[u] % BC) < bitv) ? 1 : 0;
                        e_und = (m_t[u] == FR - 1 && (m_idx[u] + 1) != nl(u) && !m_hf[u]) ? 1 : 0;
                    end
                    chk("sdi", u, sdi_w[u], e_sdi);
                    chk("busy", u, busy_w[u], (m_phase[u] != 0) ? 1 : 0);
                    chk("pixel_ready", u, prdy[u], m_hf[u] ? 0 : 1);
                    chk("underrun", u, und_w[u], e_und);
                    chk("pixel_index", u, idx_w[u], m_idx[u]);
                end
            end
        end
    end

    task automatic send_pixel(input int u, input logic [PB-1:0] d);
        int n;
        bit ok;
        pvalid[u] = 1'b1;
        pdata[u]  = d;
        n = 0;
        do begin
            ok = prdy[u];
            @(posedge clk); #2;
            n++;
        end while (!ok && n < 5000);
        pvalid[u] = 1'b0;
        if (!ok) chk("handshake_timeout", u, 0, 1);
    endtask

    task automatic wait_busy(input int u);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!busy_w[u] && n < 100);
        chk("busy_rise", u, busy_w[u], 1);
    endtask

    int hi [64];
    int tot, lat_n, n8, n16, und_n, und_k, idx0, idx1, idx2, busy_a, busy_b, busy_cnt;
    logic [PB-1:0] p_single, p_a, p_b;

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin pvalid[u] = 1'b0; pdata[u] = '0; end
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;

        // Idle after reset
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (k == 49) begin
                chk("idle_sdi", 0, sdi_w[0], 0);
                chk("idle_busy", 0, busy_w[0], 0);
                chk("idle_ready", 0, prdy[0], 1);
                chk("idle_underrun", 0, und_w[0], 0);
            end
        end

        // Single-pixel frame on N_LEDS=1
`ifdef LED_SERIALIZER_RGBW_EN
        p_single = 32'h0000_0001;
`else
        p_single = 24'hFF_0000;
`endif
        for (int b = 0; b < 64; b++) hi[b] = 0;
        tot = 0;
        @(posedge clk); #2;
        send_pixel(0, p_single);
        @(negedge clk);
        chk("load_cycle_busy", 0, busy_w[0], 0);
        chk("load_cycle_ready", 0, prdy[0], 0);
        for (int k = 0; k < FR; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("first_sdi", 0, sdi_w[0], 1);
                chk("first_busy", 0, busy_w[0], 1);
            end
            hi[k / BC] += sdi_w[0];
            tot += sdi_w[0];
        end
        for (int b = 0; b < PB; b++) begin
`ifdef LED_SERIALIZER_RGBW_EN
            chk("bit_high_len", 0, hi[b], (b == 31) ? 16 : 8);
`else
            chk("bit_high_len", 0, hi[b], (b < 8) ? 16 : 8);
`endif
        end
`ifdef LED_SERIALIZER_RGBW_EN
        chk("total_high", 0, tot, 264);
`else
        chk("total_high", 0, tot, 256);
`endif
        lat_n = 0;
        do begin @(negedge clk); if (busy_w[0]) lat_n++; end while (busy_w[0] && lat_n < 3000);
        chk("latch_len", 0, lat_n, 1200);

        // Two back-to-back pixels on N_LEDS=2
        p_a = PB'(1);
        p_b = '0;
        p_b[PB-1] = 1'b1;
        for (int b = 0; b < 64; b++) hi[b] = 0;
        und_n = 0;
        fork
            begin send_pixel(1, p_a); send_pixel(1, p_b); end
            begin
                wait_busy(1);
                for (int k = 0; k < 2 * FR; k++) begin
                    if (k > 0) @(negedge clk);
                    hi[k / BC] += sdi_w[1];
                    if (und_w[1]) und_n++;
                    if (k == 0) idx0 = idx_w[1];
                    if (k == FR) idx1 = idx_w[1];
                end
                @(negedge clk);
                idx2 = idx_w[1];
                busy_a = busy_w[1];
            end
        join
        n8 = 0;
        n16 = 0;
        for (int b = 0; b < 2 * PB; b++) begin
            if (hi[b] == 8) n8++;
            if (hi[b] == 16) n16++;
        end
        chk("b2b_zero_bits", 1, n8, 2 * PB - 2);
        chk("b2b_one_bits", 1, n16, 2);
        chk("b2b_lsb_first", 1, hi[PB-1], 16);
        chk("b2b_msb_second", 1, hi[PB], 16);
        chk("b2b_idx0", 1, idx0, 0);
        chk("b2b_idx1", 1, idx1, 1);
        chk("b2b_idx2", 1, idx2, 2);
        chk("b2b_no_underrun", 1, und_n, 0);
        chk("b2b_latch_busy", 1, busy_a, 1);

        // Underrun on N_LEDS=4 after two pixels
        und_n = 0;
        und_k = -1;
        fork
            begin send_pixel(2, PB'(32'hC3A5_5A3C)); send_pixel(2, PB'(32'h0F0F_F0F0)); end
            begin
                wait_busy(2);
                for (int k = 0; k <= 2 * FR + LAT; k++) begin
                    if (k > 0) @(negedge clk);
                    if (und_w[2]) begin
                        und_n++;
                        if (und_k < 0) und_k = k;
                    end
                    if (k == 2 * FR) idx1 = idx_w[2];
                    if (k == 2 * FR + LAT - 1) busy_a = busy_w[2];
                    if (k == 2 * FR + LAT) busy_b = busy_w[2];
                end
            end
        join
        chk("underrun_count", 2, und_n, 1);
        chk("underrun_cycle", 2, und_k, 2 * FR - 1);
        chk("underrun_idx", 2, idx1, 2);
        chk("underrun_latch_end_busy", 2, busy_a, 1);
        chk("underrun_idle_after", 2, busy_b, 0);
        send_pixel(2, PB'(32'h8000_0001));
        @(negedge clk);
        chk("newframe_idx_before", 2, idx_w[2], 2);
        @(negedge clk);
        chk("newframe_idx", 2, idx_w[2], 0);
        chk("newframe_busy", 2, busy_w[2], 1);
        chk("newframe_sdi", 2, sdi_w[2], 1);

        // Reset during a high phase with a pixel held
        send_pixel(1, PB'(32'hFFFF_FFFF));
        send_pixel(1, PB'(32'h1234_5678));
        chk("pre_reset_sdi", 1, sdi_w[1], 1);
        chk("pre_reset_held", 1, prdy[1], 0);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_sdi", 1, sdi_w[1], 0);
        chk("reset_busy", 1, busy_w[1], 0);
        chk("reset_ready", 1, prdy[1], 1);
        chk("reset_underrun", 1, und_w[1], 0);
        chk("reset_idx", 1, idx_w[1], 0);
        busy_cnt = 0;
        repeat (100) begin @(negedge clk); if (busy_w[1]) busy_cnt++; end
        chk("reset_dropped_hold", 1, busy_cnt, 0);

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
